// File: rtl/shared_counter_pool.sv
// shared_counter_pool: pool of N_SEG segments of SEG_W bits carved into variable-width counters
// Ports: clk/rst (async, active-low); cmd_valid/cmd_ready handshake with cmd_op, cmd_id,
// cmd_size, cmd_sat and load_data_in; rsp_valid/rsp_err/alloc_id response pulse;
// rdata_out/valid_data_out/last/ovf_out serial readout; data_out flat view of all segments.
module shared_counter_pool #(
   parameter int N_SEG  = 16,
   parameter int SEG_W  = 4,
   parameter int LOAD_W = 64,
   parameter int ID_W   = $clog2(N_SEG),
   parameter int SZ_W   = $clog2(N_SEG + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [2:0]             cmd_op,
   input  logic [ID_W-1:0]        cmd_id,
   input  logic [SZ_W-1:0]        cmd_size,
   input  logic                   cmd_sat,
   input  logic [LOAD_W-1:0]      load_data_in,
   output logic                   rsp_valid,
   output logic                   rsp_err,
   output logic [ID_W-1:0]        alloc_id,
   output logic [SEG_W-1:0]       rdata_out,
   output logic                   valid_data_out,
   output logic                   last,
   output logic                   ovf_out,
   output logic [N_SEG*SEG_W-1:0] data_out
);
   localparam int MAX_SEG = LOAD_W / SEG_W;
   localparam int DW = N_SEG * SEG_W;
   localparam logic [2:0] OP_INC = 3'b001, OP_ALLOC = 3'b010, OP_FREE = 3'b011, OP_LOAD = 3'b100, OP_READ = 3'b101;
   typedef enum logic {IDLE, RD} state_t;
   state_t state_q, state_d;
   logic [SEG_W-1:0] seg_q [N_SEG];
   logic [SEG_W-1:0] seg_d [N_SEG];
   logic [SZ_W-1:0] size_q [N_SEG];
   logic [SZ_W-1:0] size_d [N_SEG];
   logic [N_SEG-1:0] alloc_q, alloc_d, head_q, head_d, sat_q, sat_d, ovf_q, ovf_d;
   logic [LOAD_W-1:0] rd_val_q, rd_val_d;
   logic [SZ_W-1:0] rd_left_q, rd_left_d;
   logic rd_ovf_q, rd_ovf_d;
   logic [ID_W-1:0] rd_id_q, rd_id_d;
   logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, vld_q, vld_d, last_q, last_d, ovf_out_q, ovf_out_d;
   logic [ID_W-1:0] alloc_id_q, alloc_id_d;
   logic [SEG_W-1:0] rdata_q, rdata_d;
   logic [SZ_W-1:0] csize, b_left;
   logic id_ok, fit_ok, do_beat, b_ovf;
   logic [ID_W-1:0] fit_id, b_id;
   logic [N_SEG-1:0] rng, arng;
   logic [LOAD_W-1:0] cval, cmask, cinc, b_val;
   logic [DW-1:0] inc_p, load_p;

   function automatic logic run_free(input logic [N_SEG-1:0] a, input int s, input int n);
      logic f;
      f = s + n <= N_SEG;
      for (int k = 0; k < N_SEG; k++) if (k >= s && k < s + n && a[k]) f = 1'b0;
      return f;
   endfunction

   assign csize = size_q[cmd_id];
   assign id_ok = alloc_q[cmd_id] && head_q[cmd_id];
   // a full LOAD_W-bit counter shifts the 1 out entirely, so the subtraction yields all ones
   assign cmask = (LOAD_W'(1) << (int'(csize) * SEG_W)) - LOAD_W'(1);
   assign cinc = (cval == cmask) ? (sat_q[cmd_id] ? cmask : '0) : cval + LOAD_W'(1);
   // counter values are aligned to segment positions so each segment picks its own slice
   assign inc_p = DW'(cinc) << (int'(cmd_id) * SEG_W);
   assign load_p = DW'(load_data_in) << (int'(cmd_id) * SEG_W);
   assign cmd_ready = state_q == IDLE;

   always_comb begin
      cval = '0;
      rng = '0;
      for (int k = 0; k < N_SEG; k++) begin
         rng[k] = k >= int'(cmd_id) && k < int'(cmd_id) + int'(csize);
         if (rng[k]) cval = cval | (LOAD_W'(seg_q[k]) << ((k - int'(cmd_id)) * SEG_W));
      end
   end

   // first fit: scanning downward leaves the lowest fitting start in fit_id
   always_comb begin
      fit_ok = 1'b0;
      fit_id = '0;
      arng = '0;
      for (int s = N_SEG - 1; s >= 0; s--)
         if (cmd_size != '0 && int'(cmd_size) <= MAX_SEG && run_free(alloc_q, s, int'(cmd_size))) begin
            fit_ok = 1'b1;
            fit_id = ID_W'(s);
         end
      for (int k = 0; k < N_SEG; k++) arng[k] = fit_ok && k >= int'(fit_id) && k < int'(fit_id) + int'(cmd_size);
   end

   always_comb begin
      state_d = state_q;
      seg_d = seg_q;
      size_d = size_q;
      alloc_d = alloc_q;
      head_d = head_q;
      sat_d = sat_q;
      ovf_d = ovf_q;
      rd_val_d = rd_val_q;
      rd_left_d = rd_left_q;
      rd_ovf_d = rd_ovf_q;
      rd_id_d = rd_id_q;
      rsp_valid_d = 1'b0;
      rsp_err_d = 1'b0;
      alloc_id_d = '0;
      rdata_d = '0;
      vld_d = 1'b0;
      last_d = 1'b0;
      ovf_out_d = 1'b0;
      do_beat = 1'b0;
      b_val = rd_val_q;
      b_left = rd_left_q;
      b_ovf = rd_ovf_q;
      b_id = rd_id_q;
      if (state_q == RD) begin
         state_d = last_q ? IDLE : RD;
         do_beat = !last_q;
      end else if (cmd_valid) begin
         case (cmd_op)
            OP_INC: begin
               rsp_valid_d = 1'b1;
               rsp_err_d = !id_ok;
               if (id_ok) begin
                  for (int k = 0; k < N_SEG; k++) if (rng[k]) seg_d[k] = inc_p[k*SEG_W +: SEG_W];
                  if (cval == cmask) ovf_d[cmd_id] = 1'b1;
               end
            end
            OP_ALLOC: begin
               rsp_valid_d = 1'b1;
               rsp_err_d = !fit_ok;
               if (fit_ok) begin
                  for (int k = 0; k < N_SEG; k++) if (arng[k]) begin
                     alloc_d[k] = 1'b1;
                     seg_d[k] = '0;
                  end
                  head_d[fit_id] = 1'b1;
                  size_d[fit_id] = cmd_size;
                  sat_d[fit_id] = cmd_sat;
                  ovf_d[fit_id] = 1'b0;
                  alloc_id_d = fit_id;
               end
            end
            OP_FREE: begin
               rsp_valid_d = 1'b1;
               rsp_err_d = !id_ok;
               if (id_ok) for (int k = 0; k < N_SEG; k++) if (rng[k]) begin
                  alloc_d[k] = 1'b0;
                  head_d[k] = 1'b0;
                  sat_d[k] = 1'b0;
                  ovf_d[k] = 1'b0;
                  seg_d[k] = '0;
               end
            end
            OP_LOAD: begin
               rsp_valid_d = 1'b1;
               rsp_err_d = !id_ok;
               if (id_ok) begin
                  for (int k = 0; k < N_SEG; k++) if (rng[k]) seg_d[k] = load_p[k*SEG_W +: SEG_W];
                  ovf_d[cmd_id] = 1'b0;
               end
            end
            OP_READ: begin
               if (id_ok) begin
                  state_d = RD;
                  do_beat = 1'b1;
                  b_val = cval;
                  b_left = csize;
                  b_ovf = ovf_q[cmd_id];
                  b_id = cmd_id;
               end else begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
      // the first beat comes straight from the accept-time snapshot, later ones from the shift register
      if (do_beat) begin
         rdata_d = b_val[SEG_W-1:0];
         vld_d = 1'b1;
         rd_val_d = b_val >> SEG_W;
         rd_left_d = b_left - SZ_W'(1);
         rd_ovf_d = b_ovf;
         rd_id_d = b_id;
         if (b_left == SZ_W'(1)) begin
            last_d = 1'b1;
            ovf_out_d = b_ovf;
            rsp_valid_d = 1'b1;
            ovf_d[b_id] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         for (int k = 0; k < N_SEG; k++) begin
            seg_q[k] <= '0;
            size_q[k] <= '0;
         end
         alloc_q <= '0;
         head_q <= '0;
         sat_q <= '0;
         ovf_q <= '0;
         rd_val_q <= '0;
         rd_left_q <= '0;
         rd_ovf_q <= 1'b0;
         rd_id_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q <= 1'b0;
         alloc_id_q <= '0;
         rdata_q <= '0;
         vld_q <= 1'b0;
         last_q <= 1'b0;
         ovf_out_q <= 1'b0;
      end else begin
         state_q <= state_d;
         seg_q <= seg_d;
         size_q <= size_d;
         alloc_q <= alloc_d;
         head_q <= head_d;
         sat_q <= sat_d;
         ovf_q <= ovf_d;
         rd_val_q <= rd_val_d;
         rd_left_q <= rd_left_d;
         rd_ovf_q <= rd_ovf_d;
         rd_id_q <= rd_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q <= rsp_err_d;
         alloc_id_q <= alloc_id_d;
         rdata_q <= rdata_d;
         vld_q <= vld_d;
         last_q <= last_d;
         ovf_out_q <= ovf_out_d;
      end
   end

   always_comb for (int k = 0; k < N_SEG; k++) data_out[k*SEG_W +: SEG_W] = seg_q[k];

   assign rsp_valid = rsp_valid_q;
   assign rsp_err = rsp_err_q;
   assign alloc_id = alloc_id_q;
   assign rdata_out = rdata_q;
   assign valid_data_out = vld_q;
   assign last = last_q;
   assign ovf_out = ovf_out_q;
endmodule

// File: tb/tb_shared_counter_pool.sv
// tb_shared_counter_pool: randomized bench for shared_counter_pool against a counter-level reference model
module tb_shared_counter_pool;
   localparam logic [2:0] NOP = 3'd0, INC = 3'd1, ALLOC = 3'd2, FREE = 3'd3, LOAD = 3'd4, READ = 3'd5;
   logic clk = 1'b0, rst = 1'b0;
   logic cmd_valid = 1'b0, cmd_ready, cmd_sat = 1'b0;
   logic [2:0] cmd_op = '0;
   logic [3:0] cmd_id = '0, alloc_id, rdata_out;
   logic [4:0] cmd_size = '0;
   logic [63:0] load_data_in = '0, data_out;
   logic rsp_valid, rsp_err, valid_data_out, last, ovf_out;
   int vectors = 0, miscompares = 0;
   int m_head_of [16];
   int m_size [16];
   bit m_sat [16];
   bit m_ovf [16];
   logic [63:0] m_val [16];

   shared_counter_pool dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_id(cmd_id), .cmd_size(cmd_size), .cmd_sat(cmd_sat), .load_data_in(load_data_in),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .alloc_id(alloc_id), .rdata_out(rdata_out),
      .valid_data_out(valid_data_out), .last(last), .ovf_out(ovf_out), .data_out(data_out)
   );

   always #5 clk = ~clk;

   function automatic void m_reset();
      for (int i = 0; i < 16; i++) begin
         m_head_of[i] = -1;
         m_size[i] = 0;
         m_sat[i] = 0;
         m_ovf[i] = 0;
         m_val[i] = '0;
      end
   endfunction

   function automatic logic [63:0] m_mask(input int n);
      return n >= 16 ? '1 : (64'd1 << (4 * n)) - 64'd1;
   endfunction

   function automatic bit m_valid(input int id);
      return m_head_of[id] == id;
   endfunction

   function automatic int m_alloc(input int n, input bit sat);
      bit ok;
      if (n < 1 || n > 16) return -1;
      for (int s = 0; s + n <= 16; s++) begin
         ok = 1;
         for (int k = s; k < s + n; k++) if (m_head_of[k] != -1) ok = 0;
         if (ok) begin
            for (int k = s; k < s + n; k++) m_head_of[k] = s;
            m_size[s] = n;
            m_sat[s] = sat;
            m_ovf[s] = 0;
            m_val[s] = '0;
            return s;
         end
      end
      return -1;
   endfunction

   function automatic void m_free(input int id);
      for (int k = id; k < id + m_size[id]; k++) m_head_of[k] = -1;
      m_val[id] = '0;
      m_ovf[id] = 0;
   endfunction

   function automatic void m_inc(input int id);
      if (m_val[id] == m_mask(m_size[id])) begin
         m_ovf[id] = 1;
         m_val[id] = m_sat[id] ? m_mask(m_size[id]) : '0;
      end else m_val[id] = m_val[id] + 64'd1;
   endfunction

   function automatic logic [63:0] m_flat();
      logic [63:0] f = '0;
      for (int s = 0; s < 16; s++) if (m_valid(s)) f = f | (m_val[s] << (4 * s));
      return f;
   endfunction

   task automatic issue(input logic [2:0] op, input int id, input int sz, input logic sat, input logic [63:0] d,
                        output logic rv, output logic re, output logic [3:0] aid);
      @(negedge clk);
      for (int c = 0; c < 40 && !cmd_ready; c++) @(negedge clk);
      if (!cmd_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL cmd_ready_timeout: got 0 want 1");
      end
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_id = 4'(id);
      cmd_size = 5'(sz);
      cmd_sat = sat;
      load_data_in = d;
      @(posedge clk);
      #1;
      rv = rsp_valid;
      re = rsp_err;
      aid = alloc_id;
      cmd_valid = 1'b0;
      cmd_op = NOP;
   endtask

   task automatic do_read(input int id, output logic [63:0] v, output int nb, output logic ov,
                          output logic seen, output logic err, output logic rsp_last);
      logic rv, re;
      logic [3:0] aid;
      v = '0;
      nb = 0;
      ov = 0;
      seen = 0;
      rsp_last = 0;
      issue(READ, id, 0, 0, '0, rv, re, aid);
      err = rv && re;
      if (!err) for (int c = 0; c < 24 && !seen; c++) begin
         if (valid_data_out) begin
            if (nb < 16) v[nb*4 +: 4] = rdata_out;
            nb++;
            if (last) begin
               seen = 1;
               ov = ovf_out;
               rsp_last = rsp_valid && !rsp_err;
            end
         end
         if (!seen) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      m_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({cmd_ready, rsp_valid, rsp_err, alloc_id, rdata_out, valid_data_out, last, ovf_out, data_out} !== {1'b1, 77'd0}) begin
         miscompares++;
         $display("FAIL reset_outputs: got rdy=%b rv=%b re=%b aid=%h rd=%h v=%b l=%b o=%b d=%h want rdy=1 rest 0",
                  cmd_ready, rsp_valid, rsp_err, alloc_id, rdata_out, valid_data_out, last, ovf_out, data_out);
      end
      rst = 1'b1;
   endtask

   task automatic test_alloc();
      int sz [3] = '{3, 1, 4};
      bit st [3] = '{0, 0, 1};
      int exp;
      logic rv, re;
      logic [3:0] aid;
      for (int i = 0; i < 3; i++) begin
         exp = m_alloc(sz[i], st[i]);
         issue(ALLOC, 0, sz[i], st[i], '0, rv, re, aid);
         vectors++;
         if ({rv, re, aid} !== {1'b1, 1'b0, 4'(exp)}) begin
            miscompares++;
            $display("FAIL alloc_%0d: got rv=%b re=%b id=%0d want rv=1 re=0 id=%0d", i, rv, re, aid, exp);
         end
      end
      vectors++;
      if (data_out !== 64'd0) begin
         miscompares++;
         $display("FAIL alloc_data: got %h want 0", data_out);
      end
   endtask

   task automatic test_wrap();
      logic rv, re, ov, seen, err, rl;
      logic [3:0] aid;
      logic [63:0] v;
      int nb;
      for (int i = 0; i < 4096; i++) begin
         m_inc(0);
         issue(INC, 0, 0, 0, '0, rv, re, aid);
         vectors++;
         if ({rv, re} !== 2'b10) begin
            miscompares++;
            $display("FAIL wrap_inc_%0d: got rv=%b re=%b want rv=1 re=0", i, rv, re);
         end
      end
      vectors++;
      if (data_out !== m_flat() || m_flat() !== 64'h0) begin
         miscompares++;
         $display("FAIL wrap_data: got %h want %h", data_out, m_flat());
      end
      for (int r = 0; r < 2; r++) begin
         do_read(0, v, nb, ov, seen, err, rl);
         vectors++;
         if ({err, v, 5'(nb), ov, seen, rl} !== {1'b0, m_val[0], 5'(m_size[0]), m_ovf[0], 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap_read_%0d: got err=%b v=%h beats=%0d ovf=%b last=%b rsp=%b want err=0 v=%h beats=%0d ovf=%b last=1 rsp=1",
                     r, err, v, nb, ov, seen, rl, m_val[0], m_size[0], m_ovf[0]);
         end
         m_ovf[0] = 0;
      end
   endtask

   task automatic test_load_inc(input logic [63:0] d, input logic [63:0] want, input logic want_ovf, input string nm);
      logic rv, re, ov, seen, err, rl;
      logic [3:0] aid;
      logic [63:0] v;
      int nb;
      m_val[4] = d & m_mask(m_size[4]);
      m_ovf[4] = 0;
      issue(LOAD, 4, 0, 0, d, rv, re, aid);
      m_inc(4);
      issue(INC, 4, 0, 0, '0, rv, re, aid);
      vectors++;
      if ({rv, re, data_out} !== {2'b10, m_flat()}) begin
         miscompares++;
         $display("FAIL %s_inc: got rv=%b re=%b d=%h want rv=1 re=0 d=%h", nm, rv, re, data_out, m_flat());
      end
      do_read(4, v, nb, ov, seen, err, rl);
      vectors++;
      if ({v, 5'(nb), ov, seen} !== {want, 5'd4, want_ovf, 1'b1} || want !== m_val[4]) begin
         miscompares++;
         $display("FAIL %s_read: got v=%h beats=%0d ovf=%b last=%b want v=%h beats=4 ovf=%b last=1",
                  nm, v, nb, ov, seen, want, want_ovf);
      end
      m_ovf[4] = 0;
   endtask

   task automatic test_free_reuse();
      logic rv, re;
      logic [3:0] aid;
      int exp;
      issue(FREE, 3, 0, 0, '0, rv, re, aid);
      m_free(3);
      vectors++;
      if ({rv, re} !== 2'b10) begin
         miscompares++;
         $display("FAIL free: got rv=%b re=%b want rv=1 re=0", rv, re);
      end
      issue(INC, 3, 0, 0, '0, rv, re, aid);
      vectors++;
      if ({rv, re, data_out} !== {2'b11, m_flat()}) begin
         miscompares++;
         $display("FAIL inc_freed: got rv=%b re=%b d=%h want rv=1 re=1 d=%h", rv, re, data_out, m_flat());
      end
      exp = m_alloc(1, 0);
      issue(ALLOC, 0, 1, 0, '0, rv, re, aid);
      vectors++;
      if ({rv, re, aid} !== {2'b10, 4'd3} || exp != 3) begin
         miscompares++;
         $display("FAIL alloc_reuse: got rv=%b re=%b id=%0d want rv=1 re=0 id=3", rv, re, aid);
      end
      issue(ALLOC, 0, 17, 0, '0, rv, re, aid);
      vectors++;
      if ({rv, re, aid} !== {2'b11, 4'd0}) begin
         miscompares++;
         $display("FAIL alloc_17: got rv=%b re=%b id=%0d want rv=1 re=1 id=0", rv, re, aid);
      end
   endtask

   task automatic test_random();
      logic rv, re, ov, seen, err, rl;
      logic [3:0] aid;
      logic [63:0] v, d;
      int nb, id, sz, exp, nh;
      int heads [$];
      logic [2:0] op;
      bit sat, ok;
      for (int i = 0; i < 400; i++) begin
         heads.delete();
         for (int s = 0; s < 16; s++) if (m_valid(s)) heads.push_back(s);
         nh = heads.size();
         op = 3'($urandom_range(0, 7));
         id = (nh > 0 && $urandom_range(0, 3) != 0) ? heads[$urandom_range(0, nh - 1)] : int'($urandom_range(0, 15));
         sz = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(1, 5));
         sat = 1'($urandom_range(0, 1));
         d = {$urandom, $urandom};
         if (op == READ) begin
            do_read(id, v, nb, ov, seen, err, rl);
            ok = m_valid(id) ? ({err, v, 5'(nb), ov, seen, rl} === {1'b0, m_val[id], 5'(m_size[id]), m_ovf[id], 2'b11}) : (err === 1'b1);
            vectors++;
            if (!ok) begin
               miscompares++;
               $display("FAIL rand_read_%0d id=%0d: got err=%b v=%h beats=%0d ovf=%b want valid=%b v=%h beats=%0d ovf=%b",
                        i, id, err, v, nb, ov, m_valid(id), m_val[id], m_size[id], m_ovf[id]);
            end
            if (m_valid(id)) m_ovf[id] = 0;
         end else begin
            issue(op, id, sz, sat, d, rv, re, aid);
            exp = 0;
            case (op)
               INC: begin
                  ok = m_valid(id);
                  if (ok) m_inc(id);
               end
               ALLOC: begin
                  exp = m_alloc(sz, sat);
                  ok = exp >= 0;
                  if (!ok) exp = 0;
               end
               FREE: begin
                  ok = m_valid(id);
                  if (ok) m_free(id);
               end
               LOAD: begin
                  ok = m_valid(id);
                  if (ok) begin
                     m_val[id] = d & m_mask(m_size[id]);
                     m_ovf[id] = 0;
                  end
               end
               default: ok = 1;
            endcase
            vectors++;
            if ({rv, re, aid, data_out} !== {op inside {INC, ALLOC, FREE, LOAD}, op inside {INC, ALLOC, FREE, LOAD} && !ok, 4'(exp), m_flat()}) begin
               miscompares++;
               $display("FAIL rand_cmd_%0d op=%0d id=%0d sz=%0d: got rv=%b re=%b aid=%0d d=%h want ok=%b aid=%0d d=%h",
                        i, op, id, sz, rv, re, aid, data_out, ok, exp, m_flat());
            end
         end
      end
   endtask

   task automatic test_reset_mid_read();
      logic rv, re;
      logic [3:0] aid;
      test_reset();
      void'(m_alloc(4, 0));
      issue(ALLOC, 0, 4, 0, '0, rv, re, aid);
      issue(LOAD, 0, 0, 0, 64'h1234, rv, re, aid);
      issue(READ, 0, 0, 0, '0, rv, re, aid);
      @(posedge clk);
      #1;
      vectors++;
      if ({valid_data_out, rdata_out, last} !== {1'b1, 4'h3, 1'b0}) begin
         miscompares++;
         $display("FAIL midread_beat2: got v=%b d=%h last=%b want v=1 d=3 last=0", valid_data_out, rdata_out, last);
      end
      #2 rst = 1'b0;
      m_reset();
      #1;
      vectors++;
      if ({cmd_ready, rsp_valid, rsp_err, alloc_id, rdata_out, valid_data_out, last, ovf_out, data_out} !== {1'b1, 77'd0}) begin
         miscompares++;
         $display("FAIL midread_reset: got rdy=%b rv=%b v=%b l=%b o=%b d=%h want rdy=1 rest 0",
                  cmd_ready, rsp_valid, valid_data_out, last, ovf_out, data_out);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({last, valid_data_out, cmd_ready} !== 3'b001) begin
         miscompares++;
         $display("FAIL midread_after: got last=%b v=%b rdy=%b want last=0 v=0 rdy=1", last, valid_data_out, cmd_ready);
      end
      issue(INC, 0, 0, 0, '0, rv, re, aid);
      vectors++;
      if ({rv, re} !== 2'b11) begin
         miscompares++;
         $display("FAIL midread_freed: got rv=%b re=%b want rv=1 re=1", rv, re);
      end
   endtask

   initial begin
      test_reset();
      test_alloc();
      test_wrap();
      test_load_inc(64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAB, 1'b0, "load_aaaa");
      test_load_inc(64'hFFFF, 64'hFFFF, 1'b1, "sat_ffff");
      test_free_reuse();
      test_random();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
